// File: rtl/serial_add_pkg.sv
// Shared definitions for the nibble-serial adder controller: FSM state
// encoding and the slice width used by the shared adder.
package serial_add_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; the building block of the nibble adder.
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    // Plain sum/majority equations.
    always_comb begin
        s_o  = a_i ^ b_i ^ ci_i;
        co_o = (a_i & b_i) | (a_i & ci_i) | (b_i & ci_i);
    end

endmodule

// File: rtl/nibble_adder_ci.sv
// Combinational 4-bit ripple adder with carry-in and carry-out, built as a
// chain of full_adder cells.
import serial_add_pkg::*;

module nibble_adder_ci (
    input  logic [NIBBLE_W-1:0] a_i,
    input  logic [NIBBLE_W-1:0] b_i,
    input  logic                ci_i,
    output logic [NIBBLE_W-1:0] s_o,
    output logic                co_o
);

    logic [NIBBLE_W:0] c;

    assign c[0] = ci_i;
    assign co_o = c[NIBBLE_W];

    genvar i;
    generate
        for (i = 0; i < NIBBLE_W; i++) begin : g_bit
            full_adder u_fa (
                .a_i  (a_i[i]),
                .b_i  (b_i[i]),
                .ci_i (c[i]),
                .s_o  (s_o[i]),
                .co_o (c[i+1])
            );
        end
    endgenerate

endmodule

// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial adder controller. Operands are accepted with a valid/ready
// handshake, then one shared 4-bit adder walks the slices LSB first, one per
// cycle; the result is held with out_valid until the consumer takes it.
// Handshake: a transfer happens on a rising edge where valid && ready; the
// producer holds its data while valid is high and ready is low.
// Optional feature: define SERIAL_ADD_SUB_EN to add the op_sub port and
// subtraction (A - B via inverted B slices and carry-in seed 1).
import serial_add_pkg::*;

module nibble_serial_add_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NIBBLES-1:0]    a,
    input  logic [4*NIBBLES-1:0]    b,
`ifdef SERIAL_ADD_SUB_EN
    input  logic                    op_sub,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NIBBLES-1:0]    sum,
    output logic                    carry,
    output logic                    busy,
    output logic [1:0]              dbg_state
);

    localparam int W     = NIBBLE_W * NIBBLES;
    localparam int IDX_W = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             sub_q;
    logic             seed;

    logic [NIBBLE_W-1:0] add_a, add_b, add_s;
    logic                add_co;

`ifdef SERIAL_ADD_SUB_EN
    logic sub_d;

    assign seed = op_sub;

    // Operation select captured with the operands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sub_q <= 1'b0;
        else        sub_q <= sub_d;
    end

    // Latch op_sub only on the accept cycle.
    always_comb begin
        sub_d = sub_q;
        if (state_q == IDLE && in_valid) sub_d = op_sub;
    end
`else
    assign seed  = 1'b0;
    assign sub_q = 1'b0;
`endif

    // Slice selection feeding the single shared adder; B is inverted when subtracting.
    always_comb begin
        add_a = a_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W];
        add_b = b_q[int'(idx_q)*NIBBLE_W +: NIBBLE_W] ^ {NIBBLE_W{sub_q}};
    end

    nibble_adder_ci u_adder (
        .a_i  (add_a),
        .b_i  (add_b),
        .ci_i (carry_q),
        .s_o  (add_s),
        .co_o (add_co)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // Next-state logic: accept in IDLE, one slice per cycle in ADD, hold in DONE.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = seed;
                    sum_d   = '0;
                    state_d = ADD;
                end
            end
            ADD: begin
                sum_d[int'(idx_q)*NIBBLE_W +: NIBBLE_W] = add_s;
                carry_d = add_co;
                if (idx_q == LAST_IDX) state_d = DONE;
                else                   idx_d   = idx_q + 1'b1;
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decode straight from registered state so they never glitch.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q != IDLE);
        sum       = sum_q;
        carry     = carry_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Self-checking bench for nibble_serial_add_ctrl (NIBBLES=4). Expected
// results come from plain integer arithmetic on the operands.
module tb_nibble_serial_add_ctrl;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         op_sub = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
    logic [1:0]   dbg_state;

    int n_checks = 0;
    int n_errors = 0;

    logic [W:0] exp_q[$];

    // Clock: 10 time-unit period.
    always #5 clk = ~clk;

    nibble_serial_add_ctrl #(.NIBBLES(NIBBLES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SERIAL_ADD_SUB_EN
        .op_sub    (op_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: add -> {carry,sum} = a + b; subtract -> sum = a - b mod 2^W, carry = (a >= b).
    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        if (s) r = {(x >= y), W'(x - y)};
        else   r = {1'b0, x} + {1'b0, y};
        return r;
    endfunction

    // Offer one operand pair and push its expected result.
    task automatic accept(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        int guard = 0;
        while (!in_ready && guard < 50) begin
            tick();
            guard++;
        end
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        a = x; b = y; op_sub = s; in_valid = 1'b1;
        exp_q.push_back(model(x, y, s));
        tick();
        in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); op_sub = 1'($urandom);
    endtask

    // Wait for the result, check latency/busy/data, stall for hold cycles, then consume.
    task automatic finish_op(input int hold);
        int cyc = 0;
        logic [W:0] e;
        while (!out_valid && cyc < 50) begin
            check("busy_in_add", 32'(busy), 32'd1);
            check("in_ready_in_add", 32'(in_ready), 32'd0);
            tick();
            cyc++;
        end
        check("latency", 32'(cyc), 32'(NIBBLES));
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e[W-1:0]));
        check("carry", 32'(carry), 32'(e[W]));
        check("busy_in_done", 32'(busy), 32'd1);
        out_ready = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'($urandom);
            a = W'($urandom); b = W'($urandom);
            tick();
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
            check("hold_sum", 32'(sum), 32'(e[W-1:0]));
            check("hold_carry", 32'(carry), 32'(e[W]));
        end
        in_valid = 1'b1;   // must not be taken in the DONE->IDLE cycle
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        out_ready = 1'b0;
        check("release_valid", 32'(out_valid), 32'd0);
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_busy", 32'(busy), 32'd0);
    endtask

    task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s, input int hold);
        accept(x, y, s);
        finish_op(hold);
    endtask

    initial begin
        // Reset state.
        rst_n = 1'b0;
        #12;
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_carry", 32'(carry), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst_in_ready", 32'(in_ready), 32'd1);

        // out_ready while idle is ignored.
        out_ready = 1'b1;
        tick();
        check("idle_out_ready_ignored", 32'(out_valid), 32'd0);
        out_ready = 1'b0;

        // Carry across a slice boundary.
        run_op(16'h00FF, 16'h0001, 1'b0, 0);
        // Full wrap with carry out.
        run_op(16'hFFFF, 16'h0001, 1'b0, 0);
        // Stalled result, in_valid pulses ignored.
        run_op(16'h1357, 16'h2468, 1'b0, 3);

        // Reset on the second ADD cycle aborts the operation.
        accept(16'h1234, 16'h1111, 1'b0);
        tick();
        #1;
        rst_n = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("abort_sum", 32'(sum), 32'd0);
        check("abort_carry", 32'(carry), 32'd0);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        run_op(16'h0002, 16'h0003, 1'b0, 0);

`ifdef SERIAL_ADD_SUB_EN
        run_op(16'h0005, 16'h0007, 1'b1, 0);
        run_op(16'h0007, 16'h0005, 1'b1, 1);
        run_op(16'h0000, 16'h0000, 1'b1, 0);
`endif

        // Randomized operands and stall lengths.
        for (int i = 0; i < 25; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3));
`else
            run_op(W'($urandom), W'($urandom), 1'b0, $urandom_range(0, 3));
`endif
        end

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
